// File: rtl/fdtd_step_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fdtd_step_ctrl                                                |
// | Purpose  : Time-step sequencer for the 1-D FDTD datapath. Walks the      |
// |            Hy, Ez and source phases of each step, issues field-RAM       |
// |            reads, calc-unit enables and delayed write-back strobes, and  |
// |            counts steps up to the programmed total.                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fdtd_step_ctrl #(
   parameter int CELL_NUM   = 200,
   parameter int ADDR_WIDTH = 10,
   parameter int STEP_WIDTH = 16,
   parameter int CALC_LAT   = 2,
   parameter int SRC_ADDR   = 50
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [STEP_WIDTH-1:0] num_steps_i,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  calc_Hy_en_o,
   output logic                  calc_Ez_en_o,
   output logic                  calc_src_en_o,
   output logic                  hy_wr_en_o,
   output logic                  ez_wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [STEP_WIDTH-1:0] step_cnt_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HY     = 3'd1,
      S_HY_DR  = 3'd2,
      S_EZ     = 3'd3,
      S_EZ_DR  = 3'd4,
      S_SRC    = 3'd5,
      S_SRC_DR = 3'd6
   } state_t;

   // Phase tag carried down the delay line with each read.
   localparam logic [1:0] c_PH_HY  = 2'd0;
   localparam logic [1:0] c_PH_EZ  = 2'd1;
   localparam logic [1:0] c_PH_SRC = 2'd2;

   // Last read address of the Hy and Ez sweeps, and the source cell.
   localparam logic [ADDR_WIDTH-1:0] c_HY_LAST = ADDR_WIDTH'(CELL_NUM - 2);
   localparam logic [ADDR_WIDTH-1:0] c_EZ_LAST = ADDR_WIDTH'(CELL_NUM - 1);
   localparam logic [ADDR_WIDTH-1:0] c_SRC_AD  = ADDR_WIDTH'(SRC_ADDR);

   // Drain counter runs 0..CALC_LAT, giving 1+CALC_LAT drain cycles.
   localparam int                 c_DRN_W    = $clog2(CALC_LAT + 1) + 1;
   localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(CALC_LAT);

   state_t                  r_state;
   state_t                  w_next;

   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [ADDR_WIDTH-1:0]   w_addr_nxt;
   logic [c_DRN_W-1:0]      r_drn;
   logic [c_DRN_W-1:0]      w_drn_nxt;
   logic [STEP_WIDTH-1:0]   r_num;
   logic [STEP_WIDTH-1:0]   r_step;
   logic [STEP_WIDTH-1:0]   w_step_p1;
   logic                    r_done;

   logic                    w_rd_en;
   logic [1:0]              w_rd_ph;
   logic                    w_latch;
   logic                    w_step_clr;
   logic                    w_step_inc;
   logic                    w_done_set;

   // Delay line: stage 0 drives the calc enables, stage CALC_LAT the writes.
   logic                    r_pv  [0:CALC_LAT];
   logic [1:0]              r_pph [0:CALC_LAT];
   logic [ADDR_WIDTH-1:0]   r_pad [0:CALC_LAT];

   assign w_step_p1 = r_step + STEP_WIDTH'(1);

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode, read strobe and counter control.
   always_comb begin
      w_next     = r_state;
      w_addr_nxt = r_addr;
      w_drn_nxt  = r_drn;
      w_rd_en    = 1'b0;
      w_rd_ph    = c_PH_HY;
      w_latch    = 1'b0;
      w_step_clr = 1'b0;
      w_step_inc = 1'b0;
      w_done_set = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               if (num_steps_i != '0) begin
                  w_next     = S_HY;
                  w_latch    = 1'b1;
                  w_step_clr = 1'b1;
                  w_addr_nxt = '0;
               end else begin
                  // Zero-length run completes immediately without any activity.
                  w_done_set = 1'b1;
               end
            end
         end
         S_HY: begin
            w_rd_en = 1'b1;
            w_rd_ph = c_PH_HY;
            if (r_addr == c_HY_LAST) begin
               w_next    = S_HY_DR;
               w_drn_nxt = '0;
            end else begin
               w_addr_nxt = r_addr + ADDR_WIDTH'(1);
            end
         end
         S_HY_DR: begin
            if (r_drn == c_DRN_LAST) begin
               w_next     = S_EZ;
               w_addr_nxt = ADDR_WIDTH'(1);
            end else begin
               w_drn_nxt = r_drn + c_DRN_W'(1);
            end
         end
         S_EZ: begin
            w_rd_en = 1'b1;
            w_rd_ph = c_PH_EZ;
            if (r_addr == c_EZ_LAST) begin
               w_next    = S_EZ_DR;
               w_drn_nxt = '0;
            end else begin
               w_addr_nxt = r_addr + ADDR_WIDTH'(1);
            end
         end
         S_EZ_DR: begin
            if (r_drn == c_DRN_LAST) begin
               w_next     = S_SRC;
               w_addr_nxt = c_SRC_AD;
            end else begin
               w_drn_nxt = r_drn + c_DRN_W'(1);
            end
         end
         S_SRC: begin
            w_rd_en   = 1'b1;
            w_rd_ph   = c_PH_SRC;
            w_next    = S_SRC_DR;
            w_drn_nxt = '0;
         end
         S_SRC_DR: begin
            if (r_drn == c_DRN_LAST) begin
               if (w_step_p1 == r_num) begin
                  w_next     = S_IDLE;
                  w_done_set = 1'b1;
               end else begin
                  w_next     = S_HY;
                  w_step_inc = 1'b1;
                  w_addr_nxt = '0;
               end
            end else begin
               w_drn_nxt = r_drn + c_DRN_W'(1);
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase

      // Abort wins over everything: back to idle, no done, counter frozen.
      if (abort_i) begin
         w_next     = S_IDLE;
         w_latch    = 1'b0;
         w_step_clr = 1'b0;
         w_step_inc = 1'b0;
         w_done_set = 1'b0;
      end
   end

   // Address/drain counters, latched step total, step index and done pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_addr <= '0;
         r_drn  <= '0;
         r_num  <= '0;
         r_step <= '0;
         r_done <= 1'b0;
      end else begin
         r_addr <= w_addr_nxt;
         r_drn  <= w_drn_nxt;
         r_done <= w_done_set;
         if (w_latch) begin
            r_num <= num_steps_i;
         end
         if (w_step_clr) begin
            r_step <= '0;
         end else if (w_step_inc) begin
            r_step <= w_step_p1;
         end
      end
   end

   // Phase/address delay line; abort or reset flushes in-flight writes.
   always_ff @(posedge CLK) begin
      if (RST || abort_i) begin
         for (int k = 0; k <= CALC_LAT; k++) begin
            r_pv[k]  <= 1'b0;
            r_pph[k] <= c_PH_HY;
            r_pad[k] <= '0;
         end
      end else begin
         r_pv[0]  <= w_rd_en;
         r_pph[0] <= w_rd_ph;
         r_pad[0] <= r_addr;
         for (int k = 1; k <= CALC_LAT; k++) begin
            r_pv[k]  <= r_pv[k-1];
            r_pph[k] <= r_pph[k-1];
            r_pad[k] <= r_pad[k-1];
         end
      end
   end

   assign rd_en_o       = w_rd_en;
   assign rd_addr_o     = w_rd_en ? r_addr : '0;
   assign calc_Hy_en_o  = r_pv[0] && (r_pph[0] == c_PH_HY);
   assign calc_Ez_en_o  = r_pv[0] && (r_pph[0] == c_PH_EZ);
   assign calc_src_en_o = r_pv[0] && (r_pph[0] == c_PH_SRC);
   assign hy_wr_en_o    = r_pv[CALC_LAT] && (r_pph[CALC_LAT] == c_PH_HY);
   assign ez_wr_en_o    = r_pv[CALC_LAT] && (r_pph[CALC_LAT] != c_PH_HY);
   assign wr_addr_o     = r_pv[CALC_LAT] ? r_pad[CALC_LAT] : '0;
   assign step_cnt_o    = r_step;
   assign busy_o        = (r_state != S_IDLE);
   assign done_o        = r_done;

endmodule
`default_nettype wire
